// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core with load-use hazard detection,
// bubble insertion and a saturating count of inserted load-use bubbles.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] Ctrl_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic [31:0] SignExt_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  RTaddr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        Hold_i,
  input  logic        Flush_i,
  output logic        Stall_o,
  output logic        RegDst_o,
  output logic        ALUSrc_o,
  output logic [1:0]  ALUOp_o,
  output logic        MemWrite_o,
  output logic        MemRead_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic [31:0] RSdata_o,
  output logic [31:0] RTdata_o,
  output logic [31:0] SignExt_o,
  output logic [4:0]  RSaddr_o,
  output logic [4:0]  RTaddr_o,
  output logic [4:0]  RDaddr_o,
  output logic        Valid_o,
  output logic [15:0] StallCnt_o
);

  logic [7:0]  ctrl_q, ctrl_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [31:0] sign_ext_q, sign_ext_d;
  logic [4:0]  rs_addr_q, rs_addr_d;
  logic [4:0]  rt_addr_q, rt_addr_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        hazard;

  // Upper control bits are defined as don't-care by the decode unit.
  logic unused_ctrl;
  assign unused_ctrl = ^Ctrl_i[31:8];

  assign hazard = ctrl_q[2] && (rt_addr_q != 5'd0) &&
                  ((rt_addr_q == RSaddr_i) || (rt_addr_q == RTaddr_i));
  assign Stall_o = hazard;

  always_comb begin
    ctrl_d      = ctrl_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    sign_ext_d  = sign_ext_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rd_addr_d   = rd_addr_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    if (Hold_i) begin
      // Freeze everything.
    end else if (Flush_i || hazard) begin
      ctrl_d     = 8'd0;
      rs_data_d  = 32'd0;
      rt_data_d  = 32'd0;
      sign_ext_d = 32'd0;
      rs_addr_d  = 5'd0;
      rt_addr_d  = 5'd0;
      rd_addr_d  = 5'd0;
      valid_d    = 1'b0;
      // Only load-use bubbles are counted; a flush takes precedence.
      if (!Flush_i && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else begin
      ctrl_d     = Ctrl_i[7:0];
      rs_data_d  = RSdata_i;
      rt_data_d  = RTdata_i;
      sign_ext_d = SignExt_i;
      rs_addr_d  = RSaddr_i;
      rt_addr_d  = RTaddr_i;
      rd_addr_d  = RDaddr_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q      <= 8'd0;
      rs_data_q   <= 32'd0;
      rt_data_q   <= 32'd0;
      sign_ext_q  <= 32'd0;
      rs_addr_q   <= 5'd0;
      rt_addr_q   <= 5'd0;
      rd_addr_q   <= 5'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      ctrl_q      <= ctrl_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      sign_ext_q  <= sign_ext_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_addr_q   <= rd_addr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign RegDst_o   = ctrl_q[7];
  assign ALUSrc_o   = ctrl_q[6];
  assign ALUOp_o    = ctrl_q[5:4];
  assign MemWrite_o = ctrl_q[3];
  assign MemRead_o  = ctrl_q[2];
  assign MemtoReg_o = ctrl_q[1];
  assign RegWrite_o = ctrl_q[0];
  assign RSdata_o   = rs_data_q;
  assign RTdata_o   = rt_data_q;
  assign SignExt_o  = sign_ext_q;
  assign RSaddr_o   = rs_addr_q;
  assign RTaddr_o   = rt_addr_q;
  assign RDaddr_o   = rd_addr_q;
  assign Valid_o    = valid_q;
  assign StallCnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps plus randomized traffic, each
// compared against a behavioural model of the EX-side state.
module tb_id_ex_stage;

  typedef struct packed {
    logic        regdst;
    logic        alusrc;
    logic [1:0]  aluop;
    logic        memwrite;
    logic        memread;
    logic        memtoreg;
    logic        regwrite;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] sign_ext;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        valid;
    logic [15:0] cnt;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0, hold_i = 1'b0, flush_i = 1'b0;
  logic [31:0] ctrl_i = '0, rs_data_i = '0, rt_data_i = '0, sign_ext_i = '0;
  logic [4:0]  rs_addr_i = '0, rt_addr_i = '0, rd_addr_i = '0;
  logic        stall_o, regdst_o, alusrc_o, memwrite_o, memread_o, memtoreg_o, regwrite_o;
  logic [1:0]  aluop_o;
  logic [31:0] rs_data_o, rt_data_o, sign_ext_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic        valid_o;
  logic [15:0] stall_cnt_o;

  ex_t  dut_s;
  ex_t  m;
  int   checks = 0;
  int   errors = 0;
  logic last_stall;

  id_ex_stage dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .Ctrl_i     (ctrl_i),
    .RSdata_i   (rs_data_i),
    .RTdata_i   (rt_data_i),
    .SignExt_i  (sign_ext_i),
    .RSaddr_i   (rs_addr_i),
    .RTaddr_i   (rt_addr_i),
    .RDaddr_i   (rd_addr_i),
    .Hold_i     (hold_i),
    .Flush_i    (flush_i),
    .Stall_o    (stall_o),
    .RegDst_o   (regdst_o),
    .ALUSrc_o   (alusrc_o),
    .ALUOp_o    (aluop_o),
    .MemWrite_o (memwrite_o),
    .MemRead_o  (memread_o),
    .MemtoReg_o (memtoreg_o),
    .RegWrite_o (regwrite_o),
    .RSdata_o   (rs_data_o),
    .RTdata_o   (rt_data_o),
    .SignExt_o  (sign_ext_o),
    .RSaddr_o   (rs_addr_o),
    .RTaddr_o   (rt_addr_o),
    .RDaddr_o   (rd_addr_o),
    .Valid_o    (valid_o),
    .StallCnt_o (stall_cnt_o)
  );

  assign dut_s = {regdst_o, alusrc_o, aluop_o, memwrite_o, memread_o, memtoreg_o, regwrite_o,
                  rs_data_o, rt_data_o, sign_ext_o, rs_addr_o, rt_addr_o, rd_addr_o,
                  valid_o, stall_cnt_o};

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Load-use rule: EX holds a load writing a non-zero register that ID reads.
  function automatic logic model_hazard();
    return m.memread && (m.rt_addr != 5'd0) &&
           ((m.rt_addr == rs_addr_i) || (m.rt_addr == rt_addr_i));
  endfunction

  task automatic model_edge(input logic hz);
    if (rst_i) begin
      m = '0;
    end else if (hold_i) begin
      m = m;
    end else if (flush_i || hz) begin
      logic [15:0] c;
      c = m.cnt;
      if (!flush_i && c != 16'hFFFF) c = c + 16'd1;
      m = '0;
      m.cnt = c;
    end else begin
      m.regdst   = ctrl_i[7];
      m.alusrc   = ctrl_i[6];
      m.aluop    = {ctrl_i[5], ctrl_i[4]};
      m.memwrite = ctrl_i[3];
      m.memread  = ctrl_i[2];
      m.memtoreg = ctrl_i[1];
      m.regwrite = ctrl_i[0];
      m.rs_data  = rs_data_i;
      m.rt_data  = rt_data_i;
      m.sign_ext = sign_ext_i;
      m.rs_addr  = rs_addr_i;
      m.rt_addr  = rt_addr_i;
      m.rd_addr  = rd_addr_i;
      m.valid    = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic hold, input logic flush,
                      input logic [31:0] ctrl, input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic [31:0] se, input logic [4:0] rsa, input logic [4:0] rta,
                      input logic [4:0] rda);
    logic hz;
    @(negedge clk);
    rst_i = rst; hold_i = hold; flush_i = flush; ctrl_i = ctrl;
    rs_data_i = rsd; rt_data_i = rtd; sign_ext_i = se;
    rs_addr_i = rsa; rt_addr_i = rta; rd_addr_i = rda;
    #1;
    hz = model_hazard();
    last_stall = stall_o;
    check("stall", {135'd0, stall_o}, {135'd0, hz});
    @(posedge clk);
    model_edge(hz);
    #1;
    check("state", dut_s, m);
  endtask

  initial begin
    m = '0;
    // Reset with busy inputs.
    step(1, 0, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1, 5'd3, 5'd3, 5'd4);
    step(1, 0, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1, 5'd3, 5'd3, 5'd4);
    check("reset_state", dut_s, 136'd0);
    #1;
    check("reset_stall", {135'd0, stall_o}, 136'd0);

    // Pass-through with junk in the ignored control bits.
    step(0, 0, 0, 32'hFFFF_FFC1, 32'h1234_5678, 32'h0, 32'h0, 5'd1, 5'd2, 5'd9);
    check("pt_ctrl", {128'd0, regdst_o, alusrc_o, aluop_o, memwrite_o, memread_o, memtoreg_o,
                      regwrite_o}, {128'd0, 8'hC1});
    check("pt_rsdata", {104'd0, rs_data_o}, {104'd0, 32'h1234_5678});
    check("pt_rdaddr", {131'd0, rd_addr_o}, {131'd0, 5'd9});
    check("pt_valid", {135'd0, valid_o}, {135'd0, 1'b1});

    // Load-use: lw writes $8, then an instruction reads $8.
    step(0, 0, 0, 32'h57, 32'h0, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0);
    step(0, 0, 0, 32'hA1, 32'h11, 32'h22, 32'h20, 5'd8, 5'd3, 5'd10);
    check("lu_stall", {135'd0, last_stall}, {135'd0, 1'b1});
    check("lu_bubble", {127'd0, valid_o, memread_o, regwrite_o, aluop_o, rs_addr_o},
          {127'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0});
    check("lu_cnt", {120'd0, stall_cnt_o}, {120'd1, 16'd1} & {120'd0, 16'hFFFF});
    step(0, 0, 0, 32'hA1, 32'h11, 32'h22, 32'h20, 5'd8, 5'd3, 5'd10);
    check("lu_nostall", {135'd0, last_stall}, 136'd0);
    check("lu_capture", {126'd0, valid_o, rs_addr_o, rd_addr_o}, {126'd0, 1'b1, 5'd8, 5'd10});

    // Loads to $zero and non-load producers never stall.
    step(0, 0, 0, 32'h57, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0);
    step(0, 0, 0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
    check("zero_nostall", {135'd0, last_stall}, 136'd0);
    step(0, 0, 0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd1, 5'd5, 5'd5);
    step(0, 0, 0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd6);
    check("rtype_nostall", {135'd0, last_stall}, 136'd0);

    // Flush beats hazard: bubble without counting.
    step(0, 0, 0, 32'h57, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
    step(0, 0, 1, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd8, 5'd2, 5'd3);
    check("flush_stall", {135'd0, last_stall}, {135'd0, 1'b1});
    check("flush_cnt", {120'd0, stall_cnt_o}, {120'd0, 16'd1});

    // Hold freezes state while the hazard stays visible.
    step(0, 0, 0, 32'h57, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd2, 5'd8, 5'd3);
      check("hold_stall", {135'd0, last_stall}, {135'd0, 1'b1});
      check("hold_frozen", {126'd0, memread_o, rt_addr_o, stall_cnt_o[3:0]},
            {126'd0, 1'b1, 5'd8, 4'd1});
    end
    step(0, 0, 0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd2, 5'd8, 5'd3);
    check("hold_release_cnt", {120'd0, stall_cnt_o}, {120'd0, 16'd2});

    // Reset during a stall clears everything.
    step(0, 0, 0, 32'h57, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
    step(1, 0, 0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd8, 5'd2, 5'd3);
    check("rst_mid_stall_seen", {135'd0, last_stall}, {135'd0, 1'b1});
    step(0, 0, 0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd8, 5'd2, 5'd3);
    check("rst_mid_stall_after", {135'd0, last_stall}, 136'd0);

    // Saturation: preload the counter near its ceiling to keep the run short.
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    m.cnt = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h57, 32'h0, 32'h0, 32'h0, 5'd1, 5'd7, 5'd0);
      step(0, 0, 0, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd3, 5'd7, 5'd3);
    end
    check("sat_cnt", {120'd0, stall_cnt_o}, {120'd0, 16'hFFFF});
    step(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    check("sat_reset", {120'd0, stall_cnt_o}, 136'd0);

    // Randomized traffic on a small register window so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] c;
      c = $urandom;
      if ($urandom_range(0, 1) == 0) c[2] = 1'b1;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           c, $urandom, $urandom, $urandom, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. It sits directly downstream of the decode control unit. Each cycle it captures the 8 active control bits of the 32-bit control word, plus register-file read data, the sign-extended immediate and register addresses, and presents them to EX. When the instruction in EX is a load whose destination matches a source of the instruction in ID, it inserts a one-cycle bubble and raises a stall toward PC/IF-ID. A saturating counter records inserted load-use bubbles for performance tracking.

## Interface
- No parameters. All widths are fixed.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- Ctrl_i  in  32  decode control word. Only bits [7:0] are used: [7] RegDst, [6] ALUSrc, [5:4] ALUOp, [3] MemWrite, [2] MemRead, [1] MemtoReg, [0] RegWrite. Bits [31:8] are ignored.
- RSdata_i, RTdata_i  in  32  register-file read data.
- SignExt_i  in  32  sign-extended immediate; bits [5:0] carry funct.
- RSaddr_i, RTaddr_i, RDaddr_i  in  5  register numbers of the instruction in ID.
- Hold_i  in  1  external freeze; all state holds.
- Flush_i  in  1  branch/jump flush of the ID instruction.
- Stall_o  out  1  combinational load-use hazard; drives PC write-disable and IF/ID hold.
- RegDst_o, ALUSrc_o, MemWrite_o, MemRead_o, MemtoReg_o, RegWrite_o  out  1 each  registered control bits.
- ALUOp_o  out  2  registered ALUOp.
- RSdata_o, RTdata_o, SignExt_o  out  32 each  registered data.
- RSaddr_o, RTaddr_o, RDaddr_o  out  5 each  registered addresses.
- Valid_o  out  1  EX holds a real instruction (not a bubble).
- StallCnt_o  out  16  count of inserted load-use bubbles.

## Operation
- **Hazard (combinational):** `hazard = MemRead_o & (RTaddr_o != 0) & ((RTaddr_o == RSaddr_i) | (RTaddr_o == RTaddr_i))`. `Stall_o = hazard`, independent of Hold_i and Flush_i.
- **Per-edge update, in priority order:**
  1. rst_i: all outputs go to 0.
  2. Hold_i: every register and StallCnt_o keeps its value.
  3. Flush_i: load a bubble.
  4. hazard: load a bubble; StallCnt_o increments.
  5. Otherwise: capture Ctrl_i[7:0] into the control outputs and all data and address inputs into the corresponding outputs; Valid_o = 1.
- **Bubble contents:** all control outputs, data outputs and address outputs = 0; Valid_o = 0. Zeroing RTaddr_o guarantees no false hazard in the following cycle.
- **StallCnt_o:** 16-bit unsigned. It saturates at 0xFFFF and never wraps. It counts only hazard bubbles, not flush bubbles. It does not increment while Hold_i is asserted or Flush_i wins.
- **Simultaneous Flush_i and hazard:** the bubble is loaded and the counter does not increment. Stall_o is still 1 that cycle.
- **Reset mid-stall:** registers clear on that edge, so Stall_o is 0 in the following cycle. The counter clears to 0.

## Timing
- Register latency is 1 cycle: ID inputs at edge N appear on the outputs after edge N.
- Stall_o is valid in the same cycle as the ID inputs. It has no registered delay.
- A load-use hazard costs exactly one bubble. After the bubble, MemRead_o = 0 and Stall_o drops. The held ID instruction is then captured on the next edge.
- Reset value of every registered output is 0, including Valid_o and StallCnt_o. Stall_o evaluates to 0 while the register outputs are 0.

## Test plan
- **Reset:** assert rst_i for 2 cycles with non-zero inputs -> all outputs 0 and Stall_o = 0.
- **Pass-through:** Ctrl_i = 0x000000C1, RSdata_i = 0x1234_5678, RDaddr_i = 9 -> after 1 edge: RegDst_o = 1, ALUSrc_o = 1, RegWrite_o = 1, ALUOp_o = 00, RSdata_o = 0x12345678, RDaddr_o = 9, Valid_o = 1. Bits [31:8] of Ctrl_i set to 1 have no effect.
- **Load-use:** lw with Ctrl_i = 0x57 and RTaddr_i = 8 captured, then ID RSaddr_i = 8 -> Stall_o = 1. On the next edge: all controls 0, Valid_o = 0, StallCnt_o = 1. Stall_o = 0 the following cycle. The dependent instruction is captured one edge later.
- **$zero and non-load:** lw with RTaddr = 0 followed by RSaddr_i = 0 -> no stall. An R-type with MemRead = 0 followed by a matching RS -> no stall.
- **Flush/hold priority:**
  - Hazard with Flush_i = 1 -> bubble, counter unchanged.
  - Hazard with Hold_i = 1 for 3 cycles -> outputs frozen, Stall_o = 1 throughout, counter unchanged.
- **Saturation:** force 65,536 hazard bubbles -> StallCnt_o reaches 0xFFFF and stays there. A subsequent rst_i returns it to 0.
